// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared state encoding and default timing for mem_arb
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_WAIT_CYC     = 3;
    localparam int DEF_MAX_PRIO_RUN = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin selector, first request at or after start
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int  N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] w_pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, start} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!found && req[w_pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// mem_arb : N-channel arbiter (ch0 priority + round-robin) and async-SRAM sequencer
// Revision : 1.0
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int AW           = 23,
    parameter int DW           = 16,
    parameter int WAIT_CYC     = DEF_WAIT_CYC,
    parameter int MAX_PRIO_RUN = DEF_MAX_PRIO_RUN
) (
    input  logic                        clk,
    input  logic                        sys_rst,
    input  logic [CHANNELS-1:0]         req,
    input  logic [CHANNELS-1:0]         we,
    input  logic [2*CHANNELS-1:0]       be,
    input  logic [CHANNELS*AW-1:0]      addr,
    input  logic [CHANNELS*DW-1:0]      wdat,
    input  logic [AW-1:0]               msk,
    input  logic                        msk_on,
    output logic [CHANNELS-1:0]         ack,
    output logic [DW-1:0]               rdat,
    output logic                        busy,
    output logic [$clog2(CHANNELS)-1:0] gnt_idx,
    output logic [AW-1:0]               ram_addr,
    output logic [DW-1:0]               ram_dati,
    input  logic [DW-1:0]               ram_dato,
    output logic                        ram_ce,
    output logic                        ram_oe,
    output logic                        ram_we_lo,
    output logic                        ram_we_hi
);

    localparam int GW  = $clog2(CHANNELS);
    localparam int NRR = CHANNELS - 1;
    localparam int RW  = (NRR > 1) ? $clog2(NRR) : 1;
    localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int RCW = (MAX_PRIO_RUN > 0) ? $clog2(MAX_PRIO_RUN + 1) : 1;
    localparam logic [GW-1:0] LAST_CH = GW'(CHANNELS - 1);

    state_t         r_state;
    logic [WCW-1:0] r_wcnt;
    logic [RCW-1:0] r_run;
    logic [GW-1:0]  r_last_rr;
    logic           r_we;
    logic [1:0]     r_be;

    logic [AW-1:0]  w_addr_ch [CHANNELS];
    logic [DW-1:0]  w_wdat_ch [CHANNELS];
    logic [1:0]     w_be_ch   [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_addr_ch[c] = addr[c*AW +: AW];
        assign w_wdat_ch[c] = wdat[c*DW +: DW];
        assign w_be_ch[c]   = be[c*2 +: 2];
    end

    // Round-robin runs over channels 1..CHANNELS-1; bit k of its vector is channel k+1.
    logic [RW-1:0] w_rr_start;
    logic [RW-1:0] w_rr_idx;
    logic          w_rr_found;

    assign w_rr_start = (r_last_rr == LAST_CH) ? '0 : r_last_rr[RW-1:0];

    rr_pick #(
        .N(NRR)
    ) u_rr_pick (
        .req  (req[CHANNELS-1:1]),
        .start(w_rr_start),
        .found(w_rr_found),
        .idx  (w_rr_idx)
    );

    logic          w_pick0;
    logic [GW-1:0] w_gnt;
    logic [AW-1:0] w_gaddr;

    assign w_pick0 = req[0] && ((r_run < RCW'(MAX_PRIO_RUN)) || !w_rr_found);
    assign w_gnt   = w_pick0 ? '0 : (GW'(w_rr_idx) + GW'(1));
    assign w_gaddr = msk_on ? (w_addr_ch[w_gnt] & msk) : w_addr_ch[w_gnt];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_wcnt    <= '0;
            r_run     <= '0;
            r_last_rr <= LAST_CH;
            r_we      <= 1'b0;
            r_be      <= 2'b00;
            ack       <= '0;
            rdat      <= '0;
            busy      <= 1'b0;
            gnt_idx   <= '0;
            ram_addr  <= '0;
            ram_dati  <= '0;
            ram_ce    <= 1'b1;
            ram_oe    <= 1'b1;
            ram_we_lo <= 1'b1;
            ram_we_hi <= 1'b1;
        end else begin
            ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (req[0] || w_rr_found) begin
                        gnt_idx  <= w_gnt;
                        r_we     <= we[w_gnt];
                        r_be     <= w_be_ch[w_gnt];
                        ram_addr <= w_gaddr;
                        if (we[w_gnt]) begin
                            ram_dati <= w_wdat_ch[w_gnt];
                        end
                        ram_ce   <= 1'b0;
                        ram_oe   <= we[w_gnt];
                        busy     <= 1'b1;
                        // The run only grows while ch0 is actually starving someone.
                        if (w_pick0 && w_rr_found) begin
                            r_run <= r_run + RCW'(1);
                        end else begin
                            r_run <= '0;
                        end
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wcnt <= '0;
                    if (r_we) begin
                        ram_we_hi <= !r_be[1];
                        ram_we_lo <= !r_be[0];
                    end
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (r_wcnt == WCW'(WAIT_CYC - 1)) begin
                        ram_oe       <= 1'b1;
                        ram_we_hi    <= 1'b1;
                        ram_we_lo    <= 1'b1;
                        if (!r_we) begin
                            rdat <= ram_dato;
                        end
                        ack[gnt_idx] <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                ST_DONE: begin
                    ram_ce <= 1'b1;
                    busy   <= 1'b0;
                    if (gnt_idx != '0) begin
                        r_last_rr <= gnt_idx;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// tb_mem_arb : directed self-checking bench for mem_arb (4 channels, WAIT_CYC=3)
// Revision   : 1.0
// ============================================================================
module tb_mem_arb;

    localparam int CH = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic [CH-1:0]     req;
    logic [CH-1:0]     we;
    logic [2*CH-1:0]   be;
    logic [CH*AW-1:0]  addr;
    logic [CH*DW-1:0]  wdat;
    logic [AW-1:0]     msk;
    logic              msk_on;
    logic [CH-1:0]     ack;
    logic [DW-1:0]     rdat;
    logic              busy;
    logic [1:0]        gnt_idx;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_dati;
    logic [DW-1:0]     ram_dato;
    logic              ram_ce;
    logic              ram_oe;
    logic              ram_we_lo;
    logic              ram_we_hi;

    mem_arb #(
        .CHANNELS(CH), .AW(AW), .DW(DW), .WAIT_CYC(3), .MAX_PRIO_RUN(4)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .req(req), .we(we), .be(be), .addr(addr),
        .wdat(wdat), .msk(msk), .msk_on(msk_on), .ack(ack), .rdat(rdat),
        .busy(busy), .gnt_idx(gnt_idx), .ram_addr(ram_addr), .ram_dati(ram_dati),
        .ram_dato(ram_dato), .ram_ce(ram_ce), .ram_oe(ram_oe),
        .ram_we_lo(ram_we_lo), .ram_we_hi(ram_we_hi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise req[ch], count strobe-low cycles until the ack, then drop req and let DONE retire.
    task automatic run_access(input int ch, output int ack_cyc, output logic [CH-1:0] ack_seen,
                              output int oe_n, output int lo_n, output int hi_n);
        ack_cyc  = -1;
        ack_seen = '0;
        oe_n = 0;
        lo_n = 0;
        hi_n = 0;
        req[ch] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (!ram_oe)    oe_n++;
            if (!ram_we_lo) lo_n++;
            if (!ram_we_hi) hi_n++;
            if (ack != '0) begin
                ack_cyc  = c;
                ack_seen = ack;
                req[ch]  = 1'b0;
                break;
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ac, oe_n, lo_n, hi_n, got;
        logic [CH-1:0] av;
        logic [CH-1:0] seen [6];
        logic [CH-1:0] exp_rr [4];
        logic [CH-1:0] exp_pr [6];

        exp_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
        exp_pr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001};

        sys_rst = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdat = '0;
        msk = '0; msk_on = 1'b0; ram_dato = 16'hBEEF;
        tick(); tick();
        check("rst_strobes", {ram_ce, ram_oe, ram_we_lo, ram_we_hi}, 4'b1111);
        check("rst_addr", ram_addr, 0);
        check("rst_dati", ram_dati, 0);
        check("rst_ack", ack, 0);
        check("rst_rdat", rdat, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt_idx, 0);
        sys_rst = 1'b0;
        tick();

        // Single read on channel 2
        addr[2*AW +: AW] = 23'h12345;
        we[2] = 1'b0;
        run_access(2, ac, av, oe_n, lo_n, hi_n);
        check("rd_ack_lat", ac, 5);
        check("rd_ack_vec", av, 4'b0100);
        check("rd_oe_cycles", oe_n, 4);
        check("rd_we_cycles", lo_n + hi_n, 0);
        check("rd_rdat", rdat, 16'hBEEF);
        check("rd_addr", ram_addr, 23'h12345);
        check("rd_idle_busy", busy, 0);

        // Low-lane write on channel 1
        addr[1*AW +: AW] = 23'h00100;
        we[1] = 1'b1; be[2 +: 2] = 2'b01; wdat[1*DW +: DW] = 16'hA55A;
        run_access(1, ac, av, oe_n, lo_n, hi_n);
        check("wr_ack_lat", ac, 5);
        check("wr_ack_vec", av, 4'b0010);
        check("wr_lo_cycles", lo_n, 3);
        check("wr_hi_cycles", hi_n, 0);
        check("wr_oe_cycles", oe_n, 0);
        check("wr_dati", ram_dati, 16'hA55A);
        check("wr_rdat_held", rdat, 16'hBEEF);

        // Write with no byte enables
        be[2 +: 2] = 2'b00;
        run_access(1, ac, av, oe_n, lo_n, hi_n);
        check("wr0_ack_lat", ac, 5);
        check("wr0_ack_vec", av, 4'b0010);
        check("wr0_we_cycles", lo_n + hi_n, 0);

        // Round-robin from reset with channels 1..3 held
        we = '0;
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        for (int i = 0; i < 6; i++) seen[i] = '0;
        got = 0;
        req = 4'b1110;
        for (int c = 0; c < 60 && got < 4; c++) begin
            tick();
            if (ack != '0) begin
                seen[got] = ack;
                got++;
            end
        end
        req = '0;
        tick(); tick();
        for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), seen[i], exp_rr[i]);

        // Channel 0 priority run against a pending channel 3
        for (int i = 0; i < 6; i++) seen[i] = '0;
        got = 0;
        req = 4'b1001;
        for (int c = 0; c < 80 && got < 6; c++) begin
            tick();
            if (ack != '0) begin
                seen[got] = ack;
                got++;
            end
        end
        req = '0;
        tick(); tick();
        for (int i = 0; i < 6; i++) check($sformatf("prio_order_%0d", i), seen[i], exp_pr[i]);

        // Address masking
        addr[1*AW +: AW] = 23'h7ABCD;
        msk = 23'h0FFFF; msk_on = 1'b1;
        run_access(1, ac, av, oe_n, lo_n, hi_n);
        check("msk_addr", ram_addr, 23'h0ABCD);
        check("msk_ack_lat", ac, 5);
        msk_on = 1'b0;

        // Reset during the ACCESS phase of a write
        addr[1*AW +: AW] = 23'h00042;
        we[1] = 1'b1; be[2 +: 2] = 2'b11; wdat[1*DW +: DW] = 16'h1234;
        req[1] = 1'b1;
        tick(); tick();
        check("mid_we_low", {ram_we_hi, ram_we_lo}, 2'b00);
        sys_rst = 1'b1;
        tick();
        check("mid_rst_strobes", {ram_ce, ram_oe, ram_we_lo, ram_we_hi}, 4'b1111);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_busy", busy, 0);
        sys_rst = 1'b0;
        run_access(1, ac, av, oe_n, lo_n, hi_n);
        check("post_ack_lat", ac, 5);
        check("post_ack_vec", av, 4'b0010);
        check("post_we_cycles", lo_n + hi_n, 6);
        check("post_dati", ram_dati, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arb.md
# mem_arb

Parametrised N-channel arbiter and async-SRAM sequencer for one external 16-bit memory chip (ram0..ram3 class). It sits between the memory requesters (mapper/console path, DMA, MIO, Mega-CD logic) and the chip pins. It replaces static source selection with fixed priority for the console channel plus round-robin for the rest. A starvation guard, programmable wait states, byte-lane writes and address masking are built in.

## Interface
Parameters:
- CHANNELS, 4: number of requesters; minimum 2. Channel 0 is the latency-critical console channel.
- AW, 23: word address width.
- DW, 16: data width; exactly two byte lanes.
- WAIT_CYC, 3: ACCESS-state length in clocks; minimum 1.
- MAX_PRIO_RUN, 4: consecutive channel-0 grants allowed while another channel is pending.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  system clock (50 MHz).
- sys_rst  in  1  reset; synchronous, active-high.
- req  in  CHANNELS  access request per channel; held until ack.
- we  in  CHANNELS  1 = write, 0 = read.
- be  in  CHANNELS×2  byte enables; [1] = hi lane, [0] = lo lane.
- addr  in  CHANNELS×AW  word address per channel.
- wdat  in  CHANNELS×DW  write data per channel.
- msk  in  AW  address mask.
- msk_on  in  1  apply msk to the granted address.
- ack  out  CHANNELS  one-cycle completion pulse to the granted channel.
- rdat  out  DW  read data; valid in the ack cycle, held until the next ack.
- busy  out  1  sequencer not idle.
- gnt_idx  out  $clog2(CHANNELS)  current or last granted channel.
- ram_addr  out  AW  chip address.
- ram_dati  out  DW  chip write data.
- ram_dato  in  DW  chip read data.
- ram_ce, ram_oe, ram_we_lo, ram_we_hi  out  1  chip strobes, active-low.

## Operation
- FSM states: IDLE → SETUP → ACCESS → DONE → IDLE.
- IDLE: if any req is high, select a winner, latch its addr, wdat, we and be, and go to SETUP.
- Selection order:
  - channel 0 wins if it requests and the run counter is below MAX_PRIO_RUN;
  - otherwise round-robin over channels 1..CHANNELS-1, starting from last_rr+1 and wrapping;
  - if only channel 0 requests, channel 0 wins regardless of the counter.
- Run counter:
  - increments on each channel-0 grant made while another channel is pending;
  - clears on any non-zero grant, and on a channel-0 grant when no other channel is pending.
- SETUP: drive ram_addr = msk_on ? (addr & msk) : addr. Assert ram_ce. Assert ram_oe if this is a read. Drive ram_dati if this is a write.
- ACCESS: lasts WAIT_CYC cycles, counted by a wait counter. For writes, ram_we_hi = !be[1] and ram_we_lo = !be[0]. A write with be == 0 completes without any we strobe.
- DONE:
  - deassert all strobes except that ram_ce stays low this cycle;
  - for reads, rdat ← ram_dato as sampled at the end of ACCESS;
  - pulse ack[gnt];
  - update last_rr if gnt ≠ 0.
- Dropping req mid-access does not abort the access; the access completes and ack still pulses.
- Address and data are latched at grant; later changes on the inputs are ignored until the next grant.

## Timing
- req sampled high in IDLE at edge t → SETUP in cycle t+1 → ACCESS in cycles t+2 .. t+1+WAIT_CYC → DONE and ack at cycle t+2+WAIT_CYC.
- Latency is WAIT_CYC+2 clocks. With the default WAIT_CYC = 3, that is 5 clocks (100 ns).
- A back-to-back grant is possible in the cycle after DONE. Throughput is one access per WAIT_CYC+3 clocks.
- Write data and address are stable one full cycle before the we strobe falls and one cycle after it rises.
- Reset values:
  - ram_ce = ram_oe = ram_we_lo = ram_we_hi = 1;
  - ram_addr = 0, ram_dati = 0;
  - ack = 0, rdat = 0, busy = 0, gnt_idx = 0;
  - last_rr = CHANNELS-1, so the first round-robin grant goes to channel 1;
  - run counter = 0, state = IDLE.
- Reset asserted in any state:
  - all of the above hold at the next edge;
  - an in-flight access is dropped and gets no ack.
- busy = 1 in SETUP, ACCESS and DONE.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE);
  - the default localparams for WAIT_CYC and MAX_PRIO_RUN.
- Sub-module rr_pick: a combinational round-robin selector over a request vector with a start index.
  - Inputs: request vector and start index.
  - Outputs: found flag and winning index.
  - Instantiated once, on channels 1..CHANNELS-1.

## Test plan
- Single read, channel 2, addr 0x12345, ram_dato = 0xBEEF, WAIT_CYC = 3 → ram_oe low for 4 cycles; ack[2] 5 cycles after req; rdat = 0xBEEF.
- Write, channel 1, be = 2'b01, wdat = 0xA55A → only ram_we_lo pulses, for 3 cycles; ram_we_hi stays 1; ack[1] after 5 cycles. Repeat with be = 0 → no we strobe, ack still pulses.
- req = 4'b1110 held continuously, ch0 idle → grants in the order 1, 2, 3, 1.
- ch0 and ch3 held continuously, MAX_PRIO_RUN = 4 → grant order 0, 0, 0, 0, 3, 0, …
- msk_on = 1, msk = 0x0FFFF, addr = 0x7ABCD → ram_addr = 0x0ABCD.
- sys_rst raised in ACCESS of a write → next edge: all strobes 1, no ack, busy = 0. After reset, a ch1 request completes normally.
